// File: rtl/wb_regfile.sv
// Writeback stage: load formatting, writeback mux, x1..x31 register file and instret counter.
// Ports: clk_i, rst_ni (async, active-low); instr_WB, aludata_WB, lddata_WB, pcfour_WB,
//   WBSel_WB, RegWEn_WB (writeback controls); rs1/rs2_addr_i -> rs1/rs2_data_o (reads);
//   wbdata_o (selected writeback value); instret_o (64-bit retired count).
// Option: define WB_BYPASS_EN to forward wbdata_o to a read port addressing the rd being written.
module wb_regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] instr_WB,
    input  logic [31:0] aludata_WB,
    input  logic [31:0] lddata_WB,
    input  logic [31:0] pcfour_WB,
    input  logic [1:0]  WBSel_WB,
    input  logic        RegWEn_WB,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] wbdata_o,
    output logic [63:0] instret_o
);

    localparam logic [31:0] BUBBLE = 32'h0000_0013;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;
    logic [31:0] wbdata;
    logic        wr_en;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [63:0] instret_q;

    // Entry 0 is never written, so it stays at its reset value of zero.
    logic [31:0] rf_q [32];

    assign rd     = instr_WB[11:7];
    assign funct3 = instr_WB[14:12];
    assign off    = aludata_WB[1:0];

    // Byte lane picked by the low address bits of the aligned word.
    always_comb begin
        ld_byte = lddata_WB[7:0];
        case (off)
            2'b00: ld_byte = lddata_WB[7:0];
            2'b01: ld_byte = lddata_WB[15:8];
            2'b10: ld_byte = lddata_WB[23:16];
            2'b11: ld_byte = lddata_WB[31:24];
            default: ld_byte = lddata_WB[7:0];
        endcase
    end

    // Halfword lane uses off[1] only; off[0] is ignored and never traps.
    assign ld_half = off[1] ? lddata_WB[31:16] : lddata_WB[15:0];

    always_comb begin
        ld_fmt = lddata_WB;
        case (funct3)
            F3_LB:   ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   ld_fmt = {{16{ld_half[15]}}, ld_half};
            F3_LW:   ld_fmt = lddata_WB;
            F3_LBU:  ld_fmt = {24'h0, ld_byte};
            F3_LHU:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = lddata_WB;
        endcase
    end

    always_comb begin
        wbdata = aludata_WB;
        case (WBSel_WB)
            2'b00:   wbdata = ld_fmt;
            2'b01:   wbdata = aludata_WB;
            2'b10:   wbdata = pcfour_WB;
            2'b11:   wbdata = aludata_WB;
            default: wbdata = aludata_WB;
        endcase
    end

    assign wbdata_o = wbdata;

    // Writes to x0 are dropped here so the forwarding path never sees rd = 0.
    assign wr_en = RegWEn_WB && (rd != 5'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'h0;
            end
        end else if (wr_en) begin
            rf_q[rd] <= wbdata;
        end
    end

    assign rf_rd1 = (rs1_addr_i == 5'd0) ? 32'h0 : rf_q[rs1_addr_i];
    assign rf_rd2 = (rs2_addr_i == 5'd0) ? 32'h0 : rf_q[rs2_addr_i];

`ifdef WB_BYPASS_EN
    assign rs1_data_o = (wr_en && (rs1_addr_i == rd)) ? wbdata : rf_rd1;
    assign rs2_data_o = (wr_en && (rs2_addr_i == rd)) ? wbdata : rf_rd2;
`else
    assign rs1_data_o = rf_rd1;
    assign rs2_data_o = rf_rd2;
`endif

    // Every non-bubble instruction retires, whether or not it writes a register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret_q <= 64'h0;
        end else if (instr_WB != BUBBLE) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_o = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile.
// Expected values are queued when stimulus is driven and popped when outputs are sampled.
module tb_wb_regfile;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] instr_WB;
    logic [31:0] aludata_WB;
    logic [31:0] lddata_WB;
    logic [31:0] pcfour_WB;
    logic [1:0]  WBSel_WB;
    logic        RegWEn_WB;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [31:0] wbdata_o;
    logic [63:0] instret_o;

    always #5 clk_i = ~clk_i;

    wb_regfile dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .instr_WB   (instr_WB),
        .aludata_WB (aludata_WB),
        .lddata_WB  (lddata_WB),
        .pcfour_WB  (pcfour_WB),
        .WBSel_WB   (WBSel_WB),
        .RegWEn_WB  (RegWEn_WB),
        .rs1_addr_i (rs1_addr_i),
        .rs2_addr_i (rs2_addr_i),
        .rs1_data_o (rs1_data_o),
        .rs2_data_o (rs2_data_o),
        .wbdata_o   (wbdata_o),
        .instret_o  (instret_o)
    );

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    exp_t e;

    localparam logic [31:0] BUBBLE = 32'h0000_0013;

    function automatic logic [31:0] mk_instr(input logic [4:0] rd, input logic [2:0] f3);
        return {17'h0, f3, rd, 7'b0000011};
    endfunction

    task automatic push(input string n, input logic [63:0] v);
        sb.push_back('{n, v});
    endtask

    task automatic pop();
        if (sb.size() == 0) begin
            e = '{"empty_queue", 64'hx};
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic idle();
        instr_WB   = BUBBLE;
        RegWEn_WB  = 1'b0;
        WBSel_WB   = 2'b01;
        aludata_WB = 32'h0;
        lddata_WB  = 32'h0;
        pcfour_WB  = 32'h0;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] pc);
        @(negedge clk_i);
        instr_WB   = mk_instr(rd, 3'b010);
        RegWEn_WB  = 1'b1;
        WBSel_WB   = sel;
        aludata_WB = alu;
        pcfour_WB  = pc;
        @(posedge clk_i);
        #1;
        idle();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        idle();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 1; i < 32; i++) begin
            rs1_addr_i = 5'(i);
            rs2_addr_i = 5'(i);
            push($sformatf("reset_x%0d", i), 64'h0);
            #1;
            pop();
            checks++;
            if ({32'h0, rs1_data_o} !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, rs1_data_o, e.val[31:0]);
            end
        end
        push("reset_instret", 64'h0);
        @(posedge clk_i);
        #1;
        pop();
        checks++;
        if (instret_o !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, instret_o, e.val);
        end
    endtask

    task automatic test_regwrite();
        wr(5'd5, 2'b01, 32'hDEAD_BEEF, 32'h0);
        push("x0_wbdata_pc4", 64'h1234);
        @(negedge clk_i);
        instr_WB   = mk_instr(5'd0, 3'b010);
        RegWEn_WB  = 1'b1;
        WBSel_WB   = 2'b10;
        pcfour_WB  = 32'h1234;
        aludata_WB = 32'h5555_5555;
        #1;
        pop();
        checks++;
        if ({32'h0, wbdata_o} !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, wbdata_o, e.val[31:0]);
        end
        @(posedge clk_i);
        #1;
        idle();
        rs1_addr_i = 5'd5;
        rs2_addr_i = 5'd0;
        push("rs1_x5", 64'hDEAD_BEEF);
        push("rs2_x0", 64'h0);
        #1;
        pop();
        checks++;
        if ({32'h0, rs1_data_o} !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rs1_data_o, e.val[31:0]);
        end
        pop();
        checks++;
        if ({32'h0, rs2_data_o} !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rs2_data_o, e.val[31:0]);
        end
        // x0 must ignore an aludata-select write as well
        wr(5'd0, 2'b11, 32'hFFFF_FFFF, 32'h0);
        rs2_addr_i = 5'd0;
        push("rs2_x0_after_wr", 64'h0);
        #1;
        pop();
        checks++;
        if ({32'h0, rs2_data_o} !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rs2_data_o, e.val[31:0]);
        end
    endtask

    task automatic test_load();
        logic [2:0]  f3s  [9];
        logic [1:0]  offs [9];
        logic [31:0] exps [9];
        f3s = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b101, 3'b010, 3'b011, 3'b000, 3'b001};
        offs = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 2'b11, 2'b11};
        exps = '{32'h0000_007F, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                 32'h0000_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'hFFFF_FF80,
                 32'hFFFF_80FF};
        @(negedge clk_i);
        lddata_WB = 32'h80FF_7F01;
        WBSel_WB  = 2'b00;
        RegWEn_WB = 1'b0;
        for (int i = 0; i < 9; i++) begin
            instr_WB   = mk_instr(5'd3, f3s[i]);
            aludata_WB = {30'h1000_0000, offs[i]};
            push($sformatf("load_f3_%0d_off_%0d", f3s[i], offs[i]), {32'h0, exps[i]});
            #1;
            pop();
            checks++;
            if ({32'h0, wbdata_o} !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, wbdata_o, e.val[31:0]);
            end
        end
        // commit a formatted LB into x3 and read it back
        instr_WB   = mk_instr(5'd3, 3'b000);
        aludata_WB = 32'h0000_0003;
        RegWEn_WB  = 1'b1;
        push("load_commit_x3", 64'hFFFF_FF80);
        @(posedge clk_i);
        #1;
        idle();
        rs1_addr_i = 5'd3;
        #1;
        pop();
        checks++;
        if ({32'h0, rs1_data_o} !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rs1_data_o, e.val[31:0]);
        end
    endtask

    task automatic test_bypass();
        wr(5'd7, 2'b01, 32'h1, 32'h0);
        @(negedge clk_i);
        rs1_addr_i = 5'd7;
        rs2_addr_i = 5'd7;
        instr_WB   = mk_instr(5'd7, 3'b010);
        RegWEn_WB  = 1'b1;
        WBSel_WB   = 2'b01;
        aludata_WB = 32'hA5A5_A5A5;
`ifdef WB_BYPASS_EN
        push("same_cycle_rs1", 64'hA5A5_A5A5);
        push("same_cycle_rs2", 64'hA5A5_A5A5);
`else
        push("same_cycle_rs1", 64'h1);
        push("same_cycle_rs2", 64'h1);
`endif
        #1;
        pop();
        checks++;
        if ({32'h0, rs1_data_o} !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rs1_data_o, e.val[31:0]);
        end
        pop();
        checks++;
        if ({32'h0, rs2_data_o} !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rs2_data_o, e.val[31:0]);
        end
        push("next_cycle_rs1", 64'hA5A5_A5A5);
        push("next_cycle_rs2", 64'hA5A5_A5A5);
        @(posedge clk_i);
        #1;
        idle();
        #1;
        pop();
        checks++;
        if ({32'h0, rs1_data_o} !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rs1_data_o, e.val[31:0]);
        end
        pop();
        checks++;
        if ({32'h0, rs2_data_o} !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rs2_data_o, e.val[31:0]);
        end
    endtask

    task automatic test_instret();
        do_reset();
        push("instret_count", 64'd10);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk_i);
            instr_WB  = (i < 10) ? mk_instr(5'(i), 3'b010) : BUBBLE;
            RegWEn_WB = (i % 2 == 0);
            WBSel_WB  = 2'b01;
        end
        @(negedge clk_i);
        idle();
        pop();
        checks++;
        if (instret_o !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, instret_o, e.val);
        end
    endtask

    task automatic test_reset_mid_write();
        wr(5'd9, 2'b01, 32'h1111, 32'h0);
        @(negedge clk_i);
        rs1_addr_i = 5'd9;
        instr_WB   = mk_instr(5'd9, 3'b010);
        RegWEn_WB  = 1'b1;
        WBSel_WB   = 2'b01;
        aludata_WB = 32'hCAFE_F00D;
        #2;
        rst_ni = 1'b0;
        push("async_clear_x9", 64'h0);
        push("async_clear_instret", 64'h0);
        #1;
        pop();
        checks++;
        if ({32'h0, rs1_data_o} !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rs1_data_o, e.val[31:0]);
        end
        pop();
        checks++;
        if (instret_o !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, instret_o, e.val);
        end
        push("lost_write_x9", 64'h0);
        push("lost_write_instret", 64'h0);
        @(posedge clk_i);
        #1;
        pop();
        checks++;
        if ({32'h0, rs1_data_o} !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rs1_data_o, e.val[31:0]);
        end
        pop();
        checks++;
        if (instret_o !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, instret_o, e.val);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        push("resume_x9", 64'hCAFE_F00D);
        push("resume_instret", 64'd1);
        @(posedge clk_i);
        #1;
        idle();
        #1;
        pop();
        checks++;
        if ({32'h0, rs1_data_o} !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, rs1_data_o, e.val[31:0]);
        end
        pop();
        checks++;
        if (instret_o !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, instret_o, e.val);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk_i);
        idle();
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        push("wrap_preload", 64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        pop();
        checks++;
        if (instret_o !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, instret_o, e.val);
        end
        instr_WB = mk_instr(5'd1, 3'b010);
        push("wrap_to_zero", 64'h0);
        @(posedge clk_i);
        #1;
        idle();
        pop();
        checks++;
        if (instret_o !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, instret_o, e.val);
        end
    endtask

    initial begin
        rst_ni     = 1'b0;
        rs1_addr_i = 5'd0;
        rs2_addr_i = 5'd0;
        idle();
        test_reset();
        test_regwrite();
        test_load();
        test_bypass();
        test_instret();
        test_reset_mid_write();
        test_wrap();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish within budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have clk_i, input, 1 bit: single clock; every state element updates on its rising edge.
REQ-002 SHALL have rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have instr_WB, input, 32 bits: instruction in WB; rd = [11:7], funct3 = [14:12].
REQ-004 SHALL have aludata_WB, input, 32 bits: ALU result, which is also the load address.
REQ-005 SHALL have lddata_WB, input, 32 bits: raw aligned memory word.
REQ-006 SHALL have pcfour_WB, input, 32 bits: PC+4 value.
REQ-007 SHALL have WBSel_WB, input, 2 bits: writeback source select.
REQ-008 SHALL have RegWEn_WB, input, 1 bit: register write enable.
REQ-009 SHALL have rs1_addr_i and rs2_addr_i, inputs, 5 bits each: decode-stage read addresses.
REQ-010 SHALL have rs1_data_o and rs2_data_o, outputs, 32 bits each: read data.
REQ-011 SHALL have wbdata_o, output, 32 bits: selected writeback value.
REQ-012 SHALL have instret_o, output, 64 bits: retired-instruction counter.

Function
REQ-013 SHALL select wbdata_o combinationally by WBSel_WB: 00 = formatted load, 01 = aludata_WB, 10 = pcfour_WB, 11 = aludata_WB.
REQ-014 SHALL format load data by funct3 with byte offset off = aludata_WB[1:0]:
- 000 (LB): byte at off, sign-extended.
- 001 (LH): halfword at off[1], sign-extended.
- 010 (LW): full word.
- 100 (LBU): byte at off, zero-extended.
- 101 (LHU): halfword at off[1], zero-extended.
- any other funct3: full word.
REQ-015 SHALL ignore off[0] for halfword loads; no misalignment trap is raised.
REQ-016 SHALL hold 31 writable 32-bit registers x1..x31; x0 SHALL always read 0.
REQ-017 SHALL write wbdata_o to x[rd] on the rising clk_i edge when RegWEn_WB = 1 and rd != 0; a write to rd = 0 is discarded.
REQ-018 SHALL drive rs1_data_o and rs2_data_o combinationally from the register array (0 for address 0), subject to REQ-025/REQ-026.
REQ-019 SHALL let both read ports address the same register simultaneously, each returning identical data.
REQ-020 SHALL increment instret_o by 1 on each rising edge where instr_WB != 32'h0000_0013 (the pipeline bubble); it is not gated by RegWEn_WB.
REQ-021 SHALL wrap instret_o from 64'hFFFF_FFFF_FFFF_FFFF to 0 without a flag.

Reset
REQ-022 SHALL clear x1..x31 and instret_o to 0 immediately when rst_ni falls, independent of clk_i.
REQ-023 SHALL suppress any write and any instret_o increment on an edge where rst_ni is low, including a write already presented mid-operation.
REQ-024 SHALL resume writes and counting on the first rising clk_i edge after rst_ni rises.

Configuration
REQ-025 With WB_BYPASS_EN defined, a read port whose nonzero address equals rd while RegWEn_WB = 1 SHALL return wbdata_o in the same cycle (write-through).
REQ-026 Without WB_BYPASS_EN, that read port SHALL return the pre-write register value, and the new value SHALL be visible from the cycle after the edge.

Verification
REQ-027 Assert then release reset, then read x1..x31 -> all return 0 and instret_o = 0.
REQ-028 Write x5 via WBSel=01, aludata=32'hDEADBEEF; write x0 via WBSel=10, pcfour=32'h1234 -> rs1=5 reads 32'hDEADBEEF and rs2=0 reads 0.
REQ-029 Apply lddata=32'h80FF7F01 with aludata[1:0]=01:
- LB -> 32'h0000007F.
- LBU with off=11 -> 32'h00000080.
- LH with off=10 -> 32'hFFFF80FF.
- LHU with off=10 -> 32'h000080FF.
REQ-030 Write x7 = 32'hA5A5A5A5 while rs1_addr = 7, old x7 = 1 -> rs1_data = 32'hA5A5A5A5 with WB_BYPASS_EN, or 1 without it, in that cycle; both builds read 32'hA5A5A5A5 the next cycle.
REQ-031 Apply 10 non-bubble cycles plus 3 cycles of 32'h00000013 -> instret_o = 10.
REQ-032 Pulse rst_ni low between edges during a pending write -> the write is lost and instret_o = 0.
REQ-033 Force instret_o to all-ones, then one non-bubble cycle -> instret_o = 0.
